// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, common command bytes
// and the odd-parity helper used by both the host transmitter and the receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_BITS,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // PS/2 frames carry odd parity: the bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 line with a falling-edge pulse.
// Flops reset high, which is the idle level of both lines, so no false edge follows reset.
module ps2_sync_edge (
  input  logic clk,
  input  logic srst,
  input  logic raw,
  output logic level,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
      prev_reg <= 1'b1;
    end else begin
      meta_reg <= raw;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign level = sync_reg;
  assign fall  = prev_reg & ~sync_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, device-clocked
// bit slots, acknowledge check and an overall transfer timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       keyboard_clk,
  input  logic       data,
  output logic       keyboard_clk_oe,
  output logic       data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       done,
  output logic       ack_ok,
  output logic       timeout
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic clk_level;
  logic clk_fall;
  logic data_level;
  logic data_fall_unused;

  ps2_sync_edge u_clk_sync (
    .clk   (sys_clk),
    .srst  (rst),
    .raw   (keyboard_clk),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_sync_edge u_data_sync (
    .clk   (sys_clk),
    .srst  (rst),
    .raw   (data),
    .level (data_level),
    .fall  (data_fall_unused)
  );

  ps2_tx_state_t    state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [9:0]       shift_reg, shift_next;
  logic [3:0]       idx_reg, idx_next;
  logic             clk_oe_reg, clk_oe_next;
  logic             data_oe_reg, data_oe_next;
  logic             done_reg, done_next;
  logic             timeout_reg, timeout_next;
  logic             ack_ok_reg, ack_ok_next;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      shift_reg   <= '0;
      idx_reg     <= '0;
      clk_oe_reg  <= 1'b0;
      data_oe_reg <= 1'b0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      ack_ok_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      shift_reg   <= shift_next;
      idx_reg     <= idx_next;
      clk_oe_reg  <= clk_oe_next;
      data_oe_reg <= data_oe_next;
      done_reg    <= done_next;
      timeout_reg <= timeout_next;
      ack_ok_reg  <= ack_ok_next;
    end
  end

  // The completion pulse is issued from IDLE, so hold off new requests for that cycle.
  assign tx_ready = (state_reg == ST_IDLE) && !done_reg && !timeout_reg;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    shift_next   = shift_reg;
    idx_next     = idx_reg;
    clk_oe_next  = 1'b0;
    data_oe_next = data_oe_reg;
    done_next    = 1'b0;
    timeout_next = 1'b0;
    ack_ok_next  = ack_ok_reg;

    case (state_reg)
      ST_IDLE: begin
        data_oe_next = 1'b0;
        if (tx_valid && tx_ready) begin
          shift_next  = {1'b1, odd_parity(tx_data), tx_data};
          cnt_next    = '0;
          idx_next    = '0;
          ack_ok_next = 1'b0;
          clk_oe_next = 1'b1;
          state_next  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        data_oe_next = 1'b0;
        if (cnt_reg == INHIBIT_LAST) begin
          cnt_next     = '0;
          data_oe_next = 1'b1;
          state_next   = ST_RTS;
        end else begin
          cnt_next    = cnt_reg + CNT_W'(1);
          clk_oe_next = 1'b1;
        end
      end
      ST_RTS: begin
        cnt_next = cnt_reg + CNT_W'(1);
        // The fall that answers request-to-send is device clock 1 and already clocks out d0.
        if (clk_fall) begin
          data_oe_next = ~shift_reg[0];
          shift_next   = {1'b0, shift_reg[9:1]};
          idx_next     = 4'd1;
          state_next   = ST_BITS;
        end
      end
      ST_BITS: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (clk_fall) begin
          data_oe_next = ~shift_reg[0];
          shift_next   = {1'b0, shift_reg[9:1]};
          idx_next     = idx_reg + 4'd1;
          if (idx_reg == 4'd9) begin
            state_next = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        cnt_next     = cnt_reg + CNT_W'(1);
        data_oe_next = 1'b0;
        if (clk_fall) begin
          ack_ok_next = ~data_level;
          state_next  = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        cnt_next     = cnt_reg + CNT_W'(1);
        data_oe_next = 1'b0;
        if (clk_level && data_level) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        data_oe_next = 1'b0;
        state_next   = ST_IDLE;
      end
    endcase

    if ((state_reg == ST_RTS || state_reg == ST_BITS || state_reg == ST_ACK ||
         state_reg == ST_WAIT_IDLE) && cnt_reg == TIMEOUT_LAST) begin
      clk_oe_next  = 1'b0;
      data_oe_next = 1'b0;
      done_next    = 1'b0;
      timeout_next = 1'b1;
      state_next   = ST_IDLE;
    end
  end

  assign keyboard_clk_oe = clk_oe_reg;
  assign data_oe         = data_oe_reg;
  assign done            = done_reg;
  assign timeout         = timeout_reg;
  assign ack_ok          = ack_ok_reg;

endmodule
